dma_engine: RTL and testbench

- Memory-bus initiator that copies a block of 32-bit words from a source address to a destination address. It is a second bus master beside the CPU.
- The CPU configures it through a small memory-mapped register window on the responder side of the same bus.
- Arbitration is external. The block raises MemBus_Req and drives the master bus only in cycles where MemBus_Grant=1.

---
 rtl/dma_engine_pkg.sv | 38 +++
 rtl/dma_engine_if.sv | 35 +++
 rtl/dma_engine_regs.sv | 149 ++++++++++++++
 rtl/dma_engine.sv | 136 +++++++++++++
 tb/tb_dma_engine.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_engine_pkg.sv
// dma_engine_pkg
//   Shared definitions for the dma_engine block: register window offsets,
//   CTRL/STATUS bit positions, FSM state encoding and the default base
//   address of the register window.
//   Optional build macro: DMA_IRQ_EN (adds the irq output and CTRL bit3).
package dma_engine_pkg;

  // Default base of the 16-byte register window; bits [3:0] must be 0.
  localparam logic [31:0] DMA_BASE_ADDR_DEFAULT = 32'h4000_0030;

  // Word offsets inside the register window (Address[3:2]).
  localparam logic [1:0] SRC_OFS  = 2'd0;
  localparam logic [1:0] DST_OFS  = 2'd1;
  localparam logic [1:0] LEN_OFS  = 2'd2;
  localparam logic [1:0] CTRL_OFS = 2'd3;

  // CTRL write bits.
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_IRQ_EN   = 3;

  // STATUS read bits (remaining LEN sits in [31:16]).
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } dma_state_e;

  // Source/destination pointers are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dma_engine_if.sv
// dma_engine_if
//   Master memory-bus connection of the DMA engine.
//   Handshake: the engine holds MemBus_Req=1 while it has work. A beat
//   happens in a cycle where MemBus_Grant=1 and the engine asserts exactly
//   one of MemBus_Read / MemBus_Write; strobes are never raised while
//   MemBus_Grant=0. MemBus_Read_Data is valid combinationally in the same
//   cycle as MemBus_Read. Address/write data are 0 whenever no strobe is up.
//   dbg_state exposes the engine FSM state for observation.
//   modport master : DMA engine side
//   modport slave  : arbiter / memory side
interface dma_engine_if;
  import dma_engine_pkg::*;

  logic        MemBus_Req;
  logic        MemBus_Grant;
  logic        MemBus_Read;
  logic        MemBus_Write;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] MemBus_Read_Data;
  dma_state_e  dbg_state;

  modport master (
    output MemBus_Req, MemBus_Read, MemBus_Write,
           MemBus_Address, MemBus_Write_Data, dbg_state,
    input  MemBus_Grant, MemBus_Read_Data
  );

  modport slave (
    input  MemBus_Req, MemBus_Read, MemBus_Write,
           MemBus_Address, MemBus_Write_Data, dbg_state,
    output MemBus_Grant, MemBus_Read_Data
  );

endinterface

// File: rtl/dma_engine_regs.sv
// dma_regs
//   Register window of the DMA engine: address decode, SRC/DST/LEN/done
//   storage, pointer/count advance on each completed word, and the
//   combinational read mux.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     MemRead, MemWrite     window strobes (already decoded)
//     Address, Write_data   window byte address / write data
//     Read_data             window read data (combinational)
//     busy                  engine is copying (SRC/DST/LEN/START locked)
//     advance               a destination word was written this cycle
//     done_set              set done at this edge (wins over clear)
//     start_cmd, abort_cmd  decoded CTRL commands for the FSM
//     src, dst, len, done   current register values
//     irq_en                CTRL bit3 (only when DMA_IRQ_EN is defined)
module dma_regs
  import dma_engine_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMA_BASE_ADDR_DEFAULT,
  parameter int          LEN_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         Write_data,
  output logic [31:0]         Read_data,
  input  logic                busy,
  input  logic                advance,
  input  logic                done_set,
  output logic                start_cmd,
  output logic                abort_cmd,
  output logic [31:0]         src,
  output logic [31:0]         dst,
  output logic [LEN_BITS-1:0] len,
`ifdef DMA_IRQ_EN
  output logic                irq_en,
`endif
  output logic                done
);

  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                done_q, done_d;
`ifdef DMA_IRQ_EN
  logic                irq_en_q, irq_en_d;
`endif

  logic       hit;
  logic [1:0] ofs;
  logic       ctrl_wr;
  logic       cfg_wr;
  logic       clr_done_cmd;
  logic       start_go;
  logic       unused_addr_lsb;

  assign hit             = (Address[31:4] == BASE_ADDR[31:4]);
  assign ofs             = Address[3:2];
  assign unused_addr_lsb = ^Address[1:0];

  assign ctrl_wr      = MemWrite && hit && (ofs == CTRL_OFS);
  // Configuration registers are frozen while a copy is running.
  assign cfg_wr       = MemWrite && hit && (ofs != CTRL_OFS) && !busy;
  assign abort_cmd    = ctrl_wr && Write_data[CTRL_ABORT];
  // ABORT in the same write suppresses START; START is ignored when busy.
  assign start_cmd    = ctrl_wr && Write_data[CTRL_START] &&
                        !Write_data[CTRL_ABORT] && !busy;
  assign clr_done_cmd = ctrl_wr && Write_data[CTRL_CLR_DONE];
  assign start_go     = start_cmd && (len_q != '0);

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;
`ifdef DMA_IRQ_EN
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = Write_data[CTRL_IRQ_EN];
`endif
    if (cfg_wr) begin
      case (ofs)
        SRC_OFS: src_d = word_align(Write_data);
        DST_OFS: dst_d = word_align(Write_data);
        LEN_OFS: len_d = Write_data[LEN_BITS-1:0];
        default: ;
      endcase
    end else if (advance) begin
      // Pointers wrap naturally modulo 2^32.
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      if (len_q != '0) len_d = len_q - LEN_BITS'(1);
    end
    if (done_set) begin
      done_d = 1'b1;
    end else if (clr_done_cmd || start_go) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
`ifdef DMA_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      done_q   <= done_d;
`ifdef DMA_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  always_comb begin
    Read_data = '0;
    if (MemRead && hit) begin
      case (ofs)
        SRC_OFS: Read_data = src_q;
        DST_OFS: Read_data = dst_q;
        LEN_OFS: Read_data = 32'(len_q);
        default: begin
          Read_data[31:16]     = 16'(len_q);
          Read_data[STAT_BUSY] = busy;
          Read_data[STAT_DONE] = done_q;
`ifdef DMA_IRQ_EN
          Read_data[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
      endcase
    end
  end

  assign src  = src_q;
  assign dst  = dst_q;
  assign len  = len_q;
  assign done = done_q;
`ifdef DMA_IRQ_EN
  assign irq_en = irq_en_q;
`endif

endmodule

// File: rtl/dma_engine.sv
// dma_engine
//   Block-copy bus master. The CPU programs SRC/DST/LEN and CTRL through a
//   16-byte register window; the engine then alternates one granted read
//   and one granted write per 32-bit word until LEN reaches zero.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     MemRead, MemWrite          register-window strobes
//     Address, Write_data        register-window address / write data
//     Read_data                  register-window read data (combinational)
//     bus (dma_engine_if.master) MemBus_* master bus + dbg_state
//     irq                        done && irq_en, registered (DMA_IRQ_EN only)
//   Optional build macro: DMA_IRQ_EN.
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMA_BASE_ADDR_DEFAULT,
  parameter int          LEN_BITS  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [31:0]  Address,
  input  logic [31:0]  Write_data,
  output logic [31:0]  Read_data,
`ifdef DMA_IRQ_EN
  output logic         irq,
`endif
  dma_engine_if.master bus
);

  dma_state_e  state_q, state_d;
  logic [31:0] buf_q, buf_d;

  logic                busy;
  logic                advance;
  logic                done_set;
  logic                start_cmd;
  logic                abort_cmd;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] len;
  logic                done;
  logic                rd_beat;
  logic                wr_beat;
`ifdef DMA_IRQ_EN
  logic                irq_en;
  logic                irq_q, irq_d;
`endif

  dma_regs #(
    .BASE_ADDR (BASE_ADDR),
    .LEN_BITS  (LEN_BITS)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .busy       (busy),
    .advance    (advance),
    .done_set   (done_set),
    .start_cmd  (start_cmd),
    .abort_cmd  (abort_cmd),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef DMA_IRQ_EN
    .irq_en     (irq_en),
`endif
    .done       (done)
  );

  assign busy    = (state_q != ST_IDLE);
  assign rd_beat = (state_q == ST_RD) && bus.MemBus_Grant;
  assign wr_beat = (state_q == ST_WR) && bus.MemBus_Grant;
  // A completed write always moves the pointers, even if ABORT lands on
  // the same edge, so SRC/DST/LEN describe exactly what reached memory.
  assign advance = wr_beat;
  // done: zero-length START, or the last word written (not when aborted).
  assign done_set = (start_cmd && (len == '0)) ||
                    (wr_beat && (len == LEN_BITS'(1)) && !abort_cmd);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: if (start_cmd && (len != '0)) state_d = ST_RD;
      ST_RD: begin
        if (bus.MemBus_Grant) begin
          buf_d   = bus.MemBus_Read_Data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (bus.MemBus_Grant) begin
          state_d = (len == LEN_BITS'(1)) ? ST_IDLE : ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_cmd) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Strobes follow Grant combinationally; address/data are zeroed when idle.
  assign bus.MemBus_Req        = busy;
  assign bus.MemBus_Read       = rd_beat;
  assign bus.MemBus_Write      = wr_beat;
  assign bus.MemBus_Address    = rd_beat ? src : (wr_beat ? dst : 32'd0);
  assign bus.MemBus_Write_Data = wr_beat ? buf_q : 32'd0;
  assign bus.dbg_state         = state_q;

`ifdef DMA_IRQ_EN
  assign irq_d = done && irq_en;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine
//   Directed bench for dma_engine: word-indexed RAM model on the master bus,
//   programmable grant pattern, register-window driver tasks and a single
//   check task feeding the summary line.
module tb_dma_engine;
  import dma_engine_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0030;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
`ifdef DMA_IRQ_EN
  logic        irq;
`endif

  dma_engine_if bus ();

  dma_engine #(
    .BASE_ADDR (BASE),
    .LEN_BITS  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
`ifdef DMA_IRQ_EN
    .irq        (irq),
`endif
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- grant generator ----------------
  int   cyc = 0;
  logic g_const;
  logic g_toggle;
  logic phase_ofs;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.MemBus_Grant = g_toggle ? (cyc[0] ^ phase_ofs) : g_const;

  // ---------------- RAM model ----------------
  // Unwritten words return a fixed pattern: word i (i<16) = 0x11*(i+1).
  logic [31:0] ram [0:127];
  logic        vld [0:127];
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_bad = 0;
  logic [6:0]  mem_idx;

  function automatic logic [31:0] pat(input logic [6:0] idx);
    if (idx < 7'd16) return 32'h11 * (32'(idx) + 32'd1);
    return 32'hDEAD_0000 | 32'(idx);
  endfunction

  assign mem_idx = bus.MemBus_Address[8:2];
  assign bus.MemBus_Read_Data = vld[mem_idx] ? ram[mem_idx] : pat(mem_idx);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) vld[i] <= 1'b0;
    end else if (bus.MemBus_Write) begin
      ram[mem_idx] <= bus.MemBus_Write_Data;
      vld[mem_idx] <= 1'b1;
    end
    if (bus.MemBus_Read)  n_rd <= n_rd + 1;
    if (bus.MemBus_Write) n_wr <= n_wr + 1;
    if ((bus.MemBus_Read || bus.MemBus_Write) && !bus.MemBus_Grant) n_bad <= n_bad + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic reg_write(input logic [1:0] ofs, input logic [31:0] d);
    Address    = BASE | {28'd0, ofs, 2'b00};
    Write_data = d;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
  endtask

  task automatic reg_read(input logic [1:0] ofs, output logic [31:0] d);
    Address = BASE | {28'd0, ofs, 2'b00};
    MemRead = 1'b1;
    #1;
    d       = Read_data;
    MemRead = 1'b0;
    Address = '0;
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    reg_write(SRC_OFS, s);
    reg_write(DST_OFS, d);
    reg_write(LEN_OFS, n);
  endtask

  // Counts rising edges after the START edge until STATUS.done reads 1.
  task automatic wait_done(input int limit, output int cycles);
    logic [31:0] s;
    cycles = 0;
    reg_read(CTRL_OFS, s);
    while (!s[STAT_DONE] && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      reg_read(CTRL_OFS, s);
    end
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] rd;
  int          cyc_cnt;
  int          nr0, nw0, nb0;

  initial begin
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    Write_data = '0;
    g_const   = 1'b1;
    g_toggle  = 1'b0;
    phase_ofs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    reg_read(CTRL_OFS, rd); check("rst_status", rd, 32'h0);
    reg_read(SRC_OFS, rd);  check("rst_src", rd, 32'h0);
    check("rst_req", {31'd0, bus.MemBus_Req}, 32'h0);
    check("rst_state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});

    // Register window decode
    reg_write(SRC_OFS, 32'h0000_0203);
    reg_read(SRC_OFS, rd);  check("src_align", rd, 32'h0000_0200);
    reg_write(LEN_OFS, 32'h1234_0004);
    reg_read(LEN_OFS, rd);  check("len_upper0", rd, 32'h0000_0004);
    Address = BASE + 32'h10; MemRead = 1'b1; #1;
    check("miss_read", Read_data, 32'h0);
    MemRead = 1'b0; Address = BASE; #1;
    check("noread_zero", Read_data, 32'h0);
    Address = '0;
    @(posedge clk); #1;
`ifndef DMA_IRQ_EN
    reg_write(CTRL_OFS, 32'h8);
    reg_read(CTRL_OFS, rd); check("bit3_ignored", rd, 32'h0004_0000);
`endif

    // Copy 4 words with constant grant
    setup(32'h0, 32'h100, 32'd4);
    nr0 = n_rd; nw0 = n_wr; nb0 = n_bad;
    reg_write(CTRL_OFS, 32'h1);
    check("start_state_rd", {30'd0, bus.dbg_state}, {30'd0, ST_RD});
    wait_done(40, cyc_cnt);
    check("copy_cycles", 32'(cyc_cnt), 32'd8);
    reg_read(CTRL_OFS, rd); check("copy_status", rd, 32'h0000_0002);
    check("copy_w0", ram[64], 32'h11);
    check("copy_w1", ram[65], 32'h22);
    check("copy_w2", ram[66], 32'h33);
    check("copy_w3", ram[67], 32'h44);
    check("copy_nwr", 32'(n_wr - nw0), 32'd4);
    check("copy_nrd", 32'(n_rd - nr0), 32'd4);
    reg_read(SRC_OFS, rd);  check("copy_src_end", rd, 32'h10);
    reg_read(DST_OFS, rd);  check("copy_dst_end", rd, 32'h110);
    reg_write(CTRL_OFS, 32'h4);
    reg_read(CTRL_OFS, rd); check("clr_done", rd, 32'h0);

    // Same copy with grant toggling, first cycle after START ungranted
    setup(32'h0, 32'h180, 32'd4);
    nb0 = n_bad;
    g_toggle = 1'b1;
    reg_write(CTRL_OFS, 32'h1);
    phase_ofs = cyc[0];
    wait_done(80, cyc_cnt);
    g_toggle = 1'b0;
    check("tog_cycles", 32'(cyc_cnt), 32'd16);
    check("tog_no_bad_strobe", 32'(n_bad - nb0), 32'd0);
    check("tog_w0", ram[96], 32'h11);
    check("tog_w3", ram[99], 32'h44);
    reg_write(CTRL_OFS, 32'h4);

    // LEN=0: done next cycle, no bus access
    reg_write(LEN_OFS, 32'd0);
    nr0 = n_rd; nw0 = n_wr;
    reg_write(CTRL_OFS, 32'h1);
    wait_done(10, cyc_cnt);
    check("len0_cycles", 32'(cyc_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_access", 32'((n_rd - nr0) + (n_wr - nw0)), 32'd0);
    reg_write(CTRL_OFS, 32'h4);

    // START and ABORT in the same write: ABORT wins
    setup(32'h0, 32'h1C0, 32'd4);
    nr0 = n_rd;
    reg_write(CTRL_OFS, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    reg_read(CTRL_OFS, rd); check("start_abort_status", rd, 32'h0004_0000);
    check("start_abort_noread", 32'(n_rd - nr0), 32'd0);

    // ABORT after the third destination write; LEN write while busy ignored
    setup(32'h0, 32'h1C0, 32'd8);
    nw0 = n_wr;
    reg_write(CTRL_OFS, 32'h1);
    reg_write(LEN_OFS, 32'h77);
    cyc_cnt = 0;
    while ((n_wr - nw0) < 3 && cyc_cnt < 40) begin
      @(posedge clk);
      #1;
      cyc_cnt++;
    end
    reg_write(CTRL_OFS, 32'h2);
    check("abort_no_strobe", {30'd0, bus.MemBus_Read, bus.MemBus_Write}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_nwr", 32'(n_wr - nw0), 32'd3);
    reg_read(CTRL_OFS, rd); check("abort_status", rd, 32'h0005_0000);
    reg_read(SRC_OFS, rd);  check("abort_src", rd, 32'h0C);
    reg_read(DST_OFS, rd);  check("abort_dst", rd, 32'h1CC);
    check("abort_w2", ram[114], 32'h33);
    check("abort_w3_untouched", {31'd0, vld[115]}, 32'h0);

`ifdef DMA_IRQ_EN
    // irq follows done one cycle later and drops one cycle after CLR_DONE
    setup(32'h0, 32'h100, 32'd1);
    reg_write(CTRL_OFS, 32'h9);
    wait_done(20, cyc_cnt);
    check("irq_cycles", 32'(cyc_cnt), 32'd2);
    check("irq_low_at_done", {31'd0, irq}, 32'h0);
    reg_read(CTRL_OFS, rd); check("irq_status", rd, 32'h0000_000A);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, irq}, 32'h1);
    reg_write(CTRL_OFS, 32'hC);
    check("irq_hold", {31'd0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_fall", {31'd0, irq}, 32'h0);
`endif

    // Reset in RD while granted
    setup(32'h0, 32'h100, 32'd4);
    reg_write(CTRL_OFS, 32'h1);
    check("pre_reset_read", {31'd0, bus.MemBus_Read}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset_ctl", {29'd0, bus.MemBus_Req, bus.MemBus_Read, bus.MemBus_Write}, 32'h0);
    check("mid_reset_addr", bus.MemBus_Address, 32'h0);
    check("mid_reset_wdata", bus.MemBus_Write_Data, 32'h0);
    reg_read(CTRL_OFS, rd); check("mid_reset_status", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
